execute_stage: RTL and testbench

Execute stage of the 5-stage RISC-V pipeline, directly downstream of the decode stage's ID/EX register. Consumes the registered E-stage control and operand signals, applies forwarding muxes, computes the ALU result and branch/jump decision, and drives the PC redirect to fetch. All results needed later are captured in the EX/MEM pipeline register, which feeds the memory stage one cycle later.

---
 rtl/execute_stage_if.sv | 39 +++
 rtl/execute_stage.sv | 118 +++++++++++
 tb/tb_execute_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - E-stage inputs, redirect and EX/MEM outputs of the execute stage
//
// Purpose: bundles the ID/EX-side control/operands, hazard-unit forwarding
// selects and writeback result (driven by master), plus the fetch redirect
// and EX/MEM register contents (driven by the execute stage, slave).
interface execute_stage_if;
  logic        regwriteE, memrwE, bselE, brunE, branchE, jumpE, jalrE;
  logic [1:0]  wbselE;
  logic [3:0]  ALUselE;
  logic [2:0]  funct3E;
  logic [4:0]  rdE;
  logic [31:0] rd1E, rd2E, imm_exE, pcE, pc4E;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] resultW;

  logic        pcselE;
  logic [31:0] pctargetE;
  logic        regwriteM, memrwM;
  logic [1:0]  wbselM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;
  logic [31:0] aluresultM, writedataM, pc4M;

  modport master (
    output regwriteE, memrwE, bselE, brunE, branchE, jumpE, jalrE, wbselE,
           ALUselE, funct3E, rdE, rd1E, rd2E, imm_exE, pcE, pc4E,
           forwardAE, forwardBE, resultW,
    input  pcselE, pctargetE, regwriteM, memrwM, wbselM, funct3M, rdM,
           aluresultM, writedataM, pc4M
  );

  modport slave (
    input  regwriteE, memrwE, bselE, brunE, branchE, jumpE, jalrE, wbselE,
           ALUselE, funct3E, rdE, rd1E, rd2E, imm_exE, pcE, pc4E,
           forwardAE, forwardBE, resultW,
    output pcselE, pctargetE, regwriteM, memrwM, wbselM, funct3M, rdM,
           aluresultM, writedataM, pc4M
  );
endinterface

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32 execute stage: forwarding, ALU, branch/jump redirect, EX/MEM register
//
// Purpose: applies the forwarding muxes to the E-stage operands, computes the
// ALU result and the branch/jump decision, drives the fetch redirect
// combinationally and captures the results in the EX/MEM register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears every M output
//   ex    - execute_stage_if.slave: E inputs in; pcselE/pctargetE and M outputs out
module execute_stage (
  input  logic            clk,
  input  logic            rst_n,
  execute_stage_if.slave  ex
);

  logic [31:0] src_a, writedata, src_b, alu_y;
  logic        lt_signed, lt_unsigned, lt_sel, cmp_true;

  logic        regwrite_d, regwrite_q, memrw_d, memrw_q;
  logic [1:0]  wbsel_d, wbsel_q;
  logic [2:0]  funct3_d, funct3_q;
  logic [4:0]  rd_d, rd_q;
  logic [31:0] aluresult_d, aluresult_q, writedata_d, writedata_q, pc4_d, pc4_q;

  // Forwarding muxes; select 11 falls back to the register value.
  always_comb begin
    unique case (ex.forwardAE)
      2'b01:   src_a = ex.resultW;
      2'b10:   src_a = aluresult_q;
      default: src_a = ex.rd1E;
    endcase
    unique case (ex.forwardBE)
      2'b01:   writedata = ex.resultW;
      2'b10:   writedata = aluresult_q;
      default: writedata = ex.rd2E;
    endcase
    src_b = ex.bselE ? ex.imm_exE : writedata;
  end

  always_comb begin
    unique case (ex.ALUselE)
      4'b0000: alu_y = src_a + src_b;
      4'b0001: alu_y = src_a - src_b;
      4'b0010: alu_y = src_a & src_b;
      4'b0011: alu_y = src_a | src_b;
      4'b0100: alu_y = src_a ^ src_b;
      4'b0101: alu_y = src_a << src_b[4:0];
      4'b0110: alu_y = src_a >> src_b[4:0];
      4'b0111: alu_y = $unsigned($signed(src_a) >>> src_b[4:0]);
      4'b1000: alu_y = {31'd0, $signed(src_a) < $signed(src_b)};
      4'b1001: alu_y = {31'd0, src_a < src_b};
      default: alu_y = 32'd0;
    endcase
  end

  // Branches compare against forwarded rs2, never the immediate operand.
  always_comb begin
    lt_signed   = $signed(src_a) < $signed(writedata);
    lt_unsigned = src_a < writedata;
    lt_sel      = ex.brunE ? lt_unsigned : lt_signed;
    unique case (ex.funct3E)
      3'b000:  cmp_true = (src_a == writedata);
      3'b001:  cmp_true = (src_a != writedata);
      3'b100:  cmp_true = lt_sel;
      3'b101:  cmp_true = !lt_sel;
      3'b110:  cmp_true = lt_unsigned;
      3'b111:  cmp_true = !lt_unsigned;
      default: cmp_true = 1'b0;
    endcase
  end

  assign ex.pcselE    = ex.jumpE | (ex.branchE & cmp_true);
  assign ex.pctargetE = ex.jalrE ? ((src_a + ex.imm_exE) & 32'hFFFF_FFFE)
                                 : (ex.pcE + ex.imm_exE);

  always_comb begin
    regwrite_d  = ex.regwriteE;
    memrw_d     = ex.memrwE;
    wbsel_d     = ex.wbselE;
    funct3_d    = ex.funct3E;
    rd_d        = ex.rdE;
    aluresult_d = alu_y;
    writedata_d = writedata;
    pc4_d       = ex.pc4E;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q  <= 1'b0;
      memrw_q     <= 1'b0;
      wbsel_q     <= 2'd0;
      funct3_q    <= 3'd0;
      rd_q        <= 5'd0;
      aluresult_q <= 32'd0;
      writedata_q <= 32'd0;
      pc4_q       <= 32'd0;
    end else begin
      regwrite_q  <= regwrite_d;
      memrw_q     <= memrw_d;
      wbsel_q     <= wbsel_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      pc4_q       <= pc4_d;
    end
  end

  assign ex.regwriteM  = regwrite_q;
  assign ex.memrwM     = memrw_q;
  assign ex.wbselM     = wbsel_q;
  assign ex.funct3M    = funct3_q;
  assign ex.rdM        = rd_q;
  assign ex.aluresultM = aluresult_q;
  assign ex.writedataM = writedata_q;
  assign ex.pc4M       = pc4_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_stage_if ex_if();

  execute_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex_if)
  );

  typedef struct {
    logic        regwrite, memrw, bsel, brun, branch, jump, jalr;
    logic [1:0]  wbsel;
    logic [3:0]  alusel;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [1:0]  fwda, fwdb;
    logic [31:0] resultw;
  } in_t;

  typedef struct {
    in_t         in;
    bit          chk_alu;
    logic [31:0] alu;
    bit          chk_sel;
    logic        sel;
    bit          chk_tgt;
    logic [31:0] tgt;
    bit          chk_wd;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [31:0] tgt, alu, wd;
  } out_t;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] m_alu = 32'd0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] reg_v,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (f == 2'b01) return wb;
    if (f == 2'b10) return mem;
    return reg_v;
  endfunction

  // Reference: plain arithmetic from the instruction semantics.
  function automatic out_t ref_exec(input in_t v, input logic [31:0] prev_alu);
    out_t o;
    logic [31:0] a, wd, b, p;
    logic        lt, cmp;
    a  = pick(v.fwda, v.rd1, v.resultw, prev_alu);
    wd = pick(v.fwdb, v.rd2, v.resultw, prev_alu);
    b  = v.bsel ? v.imm : wd;
    p  = 32'd1 << b[4:0];
    case (v.alusel)
      4'd0: o.alu = a + b;
      4'd1: o.alu = a - b;
      4'd2: o.alu = a & b;
      4'd3: o.alu = a | b;
      4'd4: o.alu = a ^ b;
      4'd5: o.alu = a * p;
      4'd6: o.alu = a / p;
      4'd7: o.alu = a[31] ? ~((~a) / p) : a / p;
      4'd8: o.alu = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: o.alu = (a < b) ? 32'd1 : 32'd0;
      default: o.alu = 32'd0;
    endcase
    lt = v.brun ? (a < wd) : (int'(a) < int'(wd));
    case (v.funct3)
      3'd0: cmp = (a == wd);
      3'd1: cmp = (a != wd);
      3'd4: cmp = lt;
      3'd5: cmp = !lt;
      3'd6: cmp = (a < wd);
      3'd7: cmp = !(a < wd);
      default: cmp = 1'b0;
    endcase
    o.sel = v.jump || (v.branch && cmp);
    o.tgt = v.jalr ? ((a + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
    o.wd  = wd;
    return o;
  endfunction

  task automatic drive(input in_t v);
    ex_if.regwriteE = v.regwrite; ex_if.memrwE = v.memrw; ex_if.bselE = v.bsel;
    ex_if.brunE = v.brun; ex_if.branchE = v.branch; ex_if.jumpE = v.jump;
    ex_if.jalrE = v.jalr; ex_if.wbselE = v.wbsel; ex_if.ALUselE = v.alusel;
    ex_if.funct3E = v.funct3; ex_if.rdE = v.rd; ex_if.rd1E = v.rd1;
    ex_if.rd2E = v.rd2; ex_if.imm_exE = v.imm; ex_if.pcE = v.pc; ex_if.pc4E = v.pc4;
    ex_if.forwardAE = v.fwda; ex_if.forwardBE = v.fwdb; ex_if.resultW = v.resultw;
  endtask

  function automatic in_t rnd_in();
    in_t r;
    r.regwrite = 1'($urandom); r.memrw = 1'($urandom); r.bsel = 1'($urandom);
    r.brun = 1'($urandom); r.branch = 1'($urandom); r.jump = 1'($urandom);
    r.jalr = 1'($urandom); r.wbsel = 2'($urandom); r.alusel = 4'($urandom);
    r.funct3 = 3'($urandom); r.rd = 5'($urandom); r.rd1 = $urandom;
    r.rd2 = ($urandom_range(0, 3) == 0) ? r.rd1 : $urandom;
    r.imm = $urandom; r.pc = $urandom; r.pc4 = r.pc + 32'd4;
    r.fwda = 2'($urandom); r.fwdb = 2'($urandom); r.resultw = $urandom;
    return r;
  endfunction

  function automatic in_t alu_in(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    in_t v = '{default: '0};
    v.rd1 = a; v.imm = b; v.bsel = 1'b1; v.alusel = op; v.regwrite = 1'b1; v.wbsel = 2'b01;
    v.rd = 5'd5;
    return v;
  endfunction

  function automatic vec_t mk(input in_t v);
    vec_t t = '{default: '0};
    t.in = v;
    return t;
  endfunction

  task automatic check_m_zero(input string tag);
    chk({tag, "_regwriteM"}, 32'(ex_if.regwriteM), 32'd0);
    chk({tag, "_memrwM"}, 32'(ex_if.memrwM), 32'd0);
    chk({tag, "_wbselM"}, 32'(ex_if.wbselM), 32'd0);
    chk({tag, "_funct3M"}, 32'(ex_if.funct3M), 32'd0);
    chk({tag, "_rdM"}, 32'(ex_if.rdM), 32'd0);
    chk({tag, "_aluresultM"}, ex_if.aluresultM, 32'd0);
    chk({tag, "_writedataM"}, ex_if.writedataM, 32'd0);
    chk({tag, "_pc4M"}, ex_if.pc4M, 32'd0);
  endtask

  // One instruction: drive at negedge, check redirect, capture, check M.
  task automatic step(input vec_t t, input string tag);
    out_t o;
    @(negedge clk);
    drive(t.in);
    #1;
    o = ref_exec(t.in, m_alu);
    chk({tag, "_pcsel"}, 32'(ex_if.pcselE), 32'(o.sel));
    chk({tag, "_pctarget"}, ex_if.pctargetE, o.tgt);
    if (t.chk_sel) chk({tag, "_pcsel_k"}, 32'(ex_if.pcselE), 32'(t.sel));
    if (t.chk_tgt) chk({tag, "_pctarget_k"}, ex_if.pctargetE, t.tgt);
    @(posedge clk);
    m_alu = o.alu;
    #1;
    chk({tag, "_aluresultM"}, ex_if.aluresultM, o.alu);
    chk({tag, "_writedataM"}, ex_if.writedataM, o.wd);
    chk({tag, "_regwriteM"}, 32'(ex_if.regwriteM), 32'(t.in.regwrite));
    chk({tag, "_memrwM"}, 32'(ex_if.memrwM), 32'(t.in.memrw));
    chk({tag, "_wbselM"}, 32'(ex_if.wbselM), 32'(t.in.wbsel));
    chk({tag, "_funct3M"}, 32'(ex_if.funct3M), 32'(t.in.funct3));
    chk({tag, "_rdM"}, 32'(ex_if.rdM), 32'(t.in.rd));
    chk({tag, "_pc4M"}, ex_if.pc4M, t.in.pc4);
    if (t.chk_alu) chk({tag, "_alu_k"}, ex_if.aluresultM, t.alu);
    if (t.chk_wd) chk({tag, "_wd_k"}, ex_if.writedataM, t.wd);
  endtask

  initial begin
    in_t v;
    vec_t t;

    // Table: directed vectors with hand-derived expectations.
    t = mk(alu_in(32'd5, 32'd0, 4'd0)); t.in.bsel = 1'b0; t.in.rd2 = 32'd7;
    t.chk_alu = 1; t.alu = 32'd12; tbl.push_back(t);
    t = mk(alu_in(32'h8000_0000, 32'd1, 4'd1)); t.chk_alu = 1; t.alu = 32'h7FFF_FFFF; tbl.push_back(t);
    t = mk(alu_in(32'h8000_0000, 32'd1, 4'd7)); t.chk_alu = 1; t.alu = 32'hC000_0000; tbl.push_back(t);
    t = mk(alu_in(32'h8000_0000, 32'd1, 4'd6)); t.chk_alu = 1; t.alu = 32'h4000_0000; tbl.push_back(t);
    t = mk(alu_in(32'h8000_0000, 32'd1, 4'd8)); t.chk_alu = 1; t.alu = 32'd1; tbl.push_back(t);
    t = mk(alu_in(32'h8000_0000, 32'd1, 4'd9)); t.chk_alu = 1; t.alu = 32'd0; tbl.push_back(t);
    t = mk(alu_in(32'h8000_0000, 32'd1, 4'd15)); t.chk_alu = 1; t.alu = 32'd0; tbl.push_back(t);
    t = mk(alu_in(32'h1234_5678, 32'd0, 4'd5)); t.chk_alu = 1; t.alu = 32'h1234_5678; tbl.push_back(t);
    t = mk(alu_in(32'h8000_0000, 32'd31, 4'd7)); t.chk_alu = 1; t.alu = 32'hFFFF_FFFF; tbl.push_back(t);
    // Forwarding: first produce aluresultM=100, then select each source.
    t = mk(alu_in(32'd100, 32'd0, 4'd0)); t.chk_alu = 1; t.alu = 32'd100; tbl.push_back(t);
    t = mk(alu_in(32'd1, 32'd0, 4'd0)); t.in.fwda = 2'b10; t.in.resultw = 32'd200;
    t.chk_alu = 1; t.alu = 32'd100; tbl.push_back(t);
    t = mk(alu_in(32'd1, 32'd0, 4'd0)); t.in.fwda = 2'b01; t.in.resultw = 32'd200;
    t.chk_alu = 1; t.alu = 32'd200; tbl.push_back(t);
    t = mk(alu_in(32'd1, 32'd0, 4'd0)); t.in.fwda = 2'b11; t.in.resultw = 32'd200;
    t.chk_alu = 1; t.alu = 32'd1; tbl.push_back(t);
    // Store data takes forwarded rs2, address uses the immediate.
    t = mk(alu_in(32'h1000, 32'd8, 4'd0)); t.in.memrw = 1; t.in.regwrite = 0; t.in.rd2 = 32'd3;
    t.in.fwdb = 2'b01; t.in.resultw = 32'hDEAD_BEEF;
    t.chk_alu = 1; t.alu = 32'h1008; t.chk_wd = 1; t.wd = 32'hDEAD_BEEF; tbl.push_back(t);
    // Both muxes forwarding from different stages at once.
    t = mk(alu_in(32'd0, 32'd0, 4'd0)); t.in.bsel = 0; t.in.fwda = 2'b10; t.in.fwdb = 2'b01;
    t.in.resultw = 32'h55; t.chk_alu = 1; t.alu = 32'h105D; t.chk_wd = 1; t.wd = 32'h55; tbl.push_back(t);
    // Branches.
    v = '{default: '0}; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 32'd1; v.branch = 1; v.funct3 = 3'b100;
    t = mk(v); t.chk_sel = 1; t.sel = 1; tbl.push_back(t);
    v.funct3 = 3'b110; v.brun = 1; t = mk(v); t.chk_sel = 1; t.sel = 0; tbl.push_back(t);
    v.funct3 = 3'b100; t = mk(v); t.chk_sel = 1; t.sel = 0; tbl.push_back(t);
    v.funct3 = 3'b010; v.brun = 0; t = mk(v); t.chk_sel = 1; t.sel = 0; tbl.push_back(t);
    v = '{default: '0}; v.rd1 = 32'd5; v.rd2 = 32'd5; v.bsel = 1; v.branch = 1; v.funct3 = 3'b000;
    v.pc = 32'h100; v.imm = 32'hFFFF_FFF8;
    t = mk(v); t.chk_sel = 1; t.sel = 1; t.chk_tgt = 1; t.tgt = 32'hF8; tbl.push_back(t);
    // Jumps.
    v = '{default: '0}; v.jump = 1; v.regwrite = 1; v.wbsel = 2'b10; v.rd = 5'd1;
    v.pc = 32'h40; v.pc4 = 32'h44; v.imm = 32'h20;
    t = mk(v); t.chk_sel = 1; t.sel = 1; t.chk_tgt = 1; t.tgt = 32'h60; tbl.push_back(t);
    v.jalr = 1; v.rd1 = 32'h1001; v.imm = 32'd2;
    t = mk(v); t.chk_sel = 1; t.sel = 1; t.chk_tgt = 1; t.tgt = 32'h1002; tbl.push_back(t);
    v.rd1 = 32'hFFFF_FFF0; v.imm = 32'h13;
    t = mk(v); t.chk_tgt = 1; t.tgt = 32'h2; tbl.push_back(t);
    // Bubble.
    v = '{default: '0}; t = mk(v); tbl.push_back(t);

    // Reset held with random inputs: M stays zero across edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(rnd_in());
      @(posedge clk);
      #1;
      check_m_zero("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_m_zero("rst_release");
    m_alu = 32'd0;

    foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 300; i++) step(mk(rnd_in()), $sformatf("rnd%0d", i));

    // Mid-operation reset: M clears at once, redirect stays combinational.
    @(negedge clk);
    v = '{default: '0}; v.jump = 1; v.pc = 32'h200; v.imm = 32'h10; v.pc4 = 32'h204;
    drive(v);
    rst_n = 1'b0;
    #1;
    check_m_zero("rst_mid");
    chk("rst_mid_pcsel", 32'(ex_if.pcselE), 32'd1);
    chk("rst_mid_pctarget", ex_if.pctargetE, 32'h210);
    @(posedge clk);
    #1;
    check_m_zero("rst_mid_edge");
    @(negedge clk);
    rst_n = 1'b1;
    m_alu = 32'd0;
    for (int i = 0; i < 20; i++) step(mk(rnd_in()), $sformatf("post%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
